// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RISC-V load/store request at a time, drives data_mem, and returns an extended response.
// Optional MISALIGN_TRAP_EN: when defined, accesses whose address is not a multiple of their size are rejected.
module load_store_unit #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [3:0]        mem_wr_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic [2:0] {IDLE, ST_ISSUE, LD_ISSUE, LD_WAIT, RESP} state_t;

    state_t              state, state_next;
    logic [2:0]          lat_funct3;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                accept;
    logic                req_err;
    logic [3:0]          req_size;
    logic [3:0]          lat_size;
    logic [ADDR_W:0]     req_end;
    logic [DATA_W-1:0]   le_data;
    logic [DATA_W-1:0]   ld_result;

    assign accept   = req_valid && (state == IDLE);
    assign req_size = 4'd1 << req_funct3[1:0];
    assign lat_size = 4'd1 << lat_funct3[1:0];
    // One extra bit so an access running past the top of memory cannot wrap to a legal address.
    assign req_end  = {1'b0, req_addr} + (ADDR_W+1)'(req_size);

    always_comb begin
        req_err = 1'b0;
        if (req_we && req_funct3[2])
            req_err = 1'b1;
        if (!req_we && (req_funct3 == 3'b111))
            req_err = 1'b1;
        if (req_end > {1'b1, {ADDR_W{1'b0}}})
            req_err = 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (({1'b0, req_addr[2:0]} & (req_size - 4'd1)) != 4'd0)
            req_err = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_len  = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = req_err ? RESP : (req_we ? ST_ISSUE : LD_ISSUE);
            end
            ST_ISSUE: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = lat_addr;
                mem_wr_data = lat_wdata;
                mem_wr_len  = lat_size;
                state_next  = RESP;
            end
            LD_ISSUE: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = lat_addr;
                state_next  = LD_WAIT;
            end
            LD_WAIT: state_next = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory returns the lowest-addressed byte in the top lane; flip to a little-endian value first.
    always_comb begin
        for (int k = 0; k < 8; k++)
            le_data[8*k +: 8] = mem_rd_data[63-8*k -: 8];
        case (lat_funct3)
            3'b000:  ld_result = {{56{le_data[7]}},  le_data[7:0]};
            3'b001:  ld_result = {{48{le_data[15]}}, le_data[15:0]};
            3'b010:  ld_result = {{32{le_data[31]}}, le_data[31:0]};
            3'b100:  ld_result = {56'd0, le_data[7:0]};
            3'b101:  ld_result = {48'd0, le_data[15:0]};
            3'b110:  ld_result = {32'd0, le_data[31:0]};
            default: ld_result = le_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_funct3 <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                rdata_q    <= '0;
                err_q      <= req_err;
            end
            if (state == LD_WAIT)
                rdata_q <= ld_result;
            if ((state == RESP) && resp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory model plus a byte-level reference of memory contents.
module tb_load_store_unit;

    localparam int ADDR_W    = 11;
    localparam int MEM_BYTES = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [63:0]       req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [63:0]       mem_wr_data;
    logic [3:0]        mem_wr_len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [63:0]       mem_rd_data = '0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  dut_mem [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [63:0] last_rdata;
    logic        last_err;

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_len(mem_wr_len), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // data_mem stand-in: byte-wide writes, registered 8-byte big-lane read.
    always @(posedge clk) begin
        if (mem_wr_en)
            for (int k = 0; k < 8; k++)
                if (k < int'(mem_wr_len))
                    dut_mem[(int'(mem_wr_addr) + k) % MEM_BYTES] <= mem_wr_data[8*k +: 8];
        if (mem_rd_en)
            for (int k = 0; k < 8; k++)
                mem_rd_data[63-8*k -: 8] <= dut_mem[(int'(mem_rd_addr) + k) % MEM_BYTES];
    end

    function automatic logic refErr(input logic we, input logic [2:0] f3, input int addr);
        int size;
        logic e;
        size = 1 << f3[1:0];
        e = (we && f3[2]) || (!we && f3 == 3'b111) || (addr + size > MEM_BYTES);
`ifdef MISALIGN_TRAP_EN
        if (addr % size != 0)
            e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [63:0] refLoad(input logic [2:0] f3, input int addr);
        int size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        v = '0;
        for (int k = 0; k < size; k++)
            v = v | (64'(ref_mem[addr + k]) << (8*k));
        if (!f3[2] && size < 8 && v[8*size-1])
            v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*size));
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input int addr,
                                 input logic [63:0] wdata, input int stall);
        logic        exp_err;
        int          size, resp_cyc, wr_cnt, rd_cnt, strobe_cyc, exp_cyc;
        logic [63:0] exp_rdata;
        logic [ADDR_W-1:0] cap_addr;
        logic [63:0] cap_data;
        logic [3:0]  cap_len;
        logic        both;
        size      = 1 << f3[1:0];
        exp_err   = refErr(we, f3, addr);
        exp_rdata = (exp_err || we) ? 64'd0 : refLoad(f3, addr);
        exp_cyc   = exp_err ? 1 : (we ? 2 : 3);
        resp_cyc = 0; wr_cnt = 0; rd_cnt = 0; strobe_cyc = 0; both = 1'b0;
        cap_addr = '0; cap_data = '0; cap_len = '0;

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = ADDR_W'(addr);
        req_wdata  = wdata;
        checkOutput("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        for (int c = 1; c <= 10 && resp_cyc == 0; c++) begin
            @(negedge clk);
            if (mem_wr_en) begin
                wr_cnt++; strobe_cyc = c;
                cap_addr = mem_wr_addr; cap_data = mem_wr_data; cap_len = mem_wr_len;
            end
            if (mem_rd_en) begin
                rd_cnt++; strobe_cyc = c; cap_addr = mem_rd_addr;
            end
            if (mem_wr_en && mem_rd_en)
                both = 1'b1;
            if (resp_valid)
                resp_cyc = c;
        end

        checkOutput("resp_latency", 64'(resp_cyc), 64'(exp_cyc));
        checkOutput("wr_strobes", 64'(wr_cnt), 64'((we && !exp_err) ? 1 : 0));
        checkOutput("rd_strobes", 64'(rd_cnt), 64'((!we && !exp_err) ? 1 : 0));
        checkOutput("both_strobes", 64'(both), 64'd0);
        if (!exp_err) begin
            checkOutput("strobe_cycle", 64'(strobe_cyc), 64'd1);
            checkOutput("mem_addr", 64'(cap_addr), 64'(addr));
            if (we) begin
                checkOutput("mem_wr_data", cap_data, wdata);
                checkOutput("mem_wr_len", 64'(cap_len), 64'(size));
            end
        end
        checkOutput("resp_err", 64'(resp_err), 64'(exp_err));
        checkOutput("resp_rdata", resp_rdata, exp_rdata);
        checkOutput("req_ready_busy", 64'(req_ready), 64'd0);
        last_rdata = resp_rdata;
        last_err   = resp_err;

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", 64'(resp_valid), 64'd1);
            checkOutput("stall_rdata", resp_rdata, exp_rdata);
            checkOutput("stall_err", 64'(resp_err), 64'(exp_err));
            checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
        end

        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checkOutput("post_hs_valid", 64'(resp_valid), 64'd0);
        checkOutput("post_hs_ready", 64'(req_ready), 64'd1);
        checkOutput("post_hs_rdata", resp_rdata, 64'd0);
        checkOutput("post_hs_err", 64'(resp_err), 64'd0);

        if (we && !exp_err)
            for (int k = 0; k < size; k++)
                ref_mem[addr + k] = wdata[8*k +: 8];
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            ref_mem[i] = 8'($urandom);
            dut_mem[i] = ref_mem[i];
        end

        #2;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
        checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset_strobes", 64'({mem_wr_en, mem_rd_en}), 64'd0);
        checkOutput("reset_rdata", resp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b1, 3'b011, 'h010, 64'h1122334455667788, 0);
        applyStimulus(1'b0, 3'b011, 'h010, 64'd0, 0);
        checkOutput("ld_after_sd", last_rdata, 64'h1122334455667788);

        applyStimulus(1'b1, 3'b000, 'h005, 64'h0000000000000080, 0);
        applyStimulus(1'b0, 3'b000, 'h005, 64'd0, 0);
        checkOutput("lb_sign", last_rdata, 64'hFFFFFFFFFFFFFF80);
        applyStimulus(1'b0, 3'b100, 'h005, 64'd0, 0);
        checkOutput("lbu_zero", last_rdata, 64'h0000000000000080);

        applyStimulus(1'b1, 3'b010, 'h020, 64'h0000000089ABCDEF, 0);
        applyStimulus(1'b0, 3'b010, 'h020, 64'd0, 0);
        checkOutput("lw_sign", last_rdata, 64'hFFFFFFFF89ABCDEF);
        applyStimulus(1'b0, 3'b110, 'h020, 64'd0, 0);
        checkOutput("lwu_zero", last_rdata, 64'h0000000089ABCDEF);
        applyStimulus(1'b0, 3'b001, 'h022, 64'd0, 0);
        checkOutput("lh_upper", last_rdata, 64'hFFFFFFFFFFFF89AB);

        applyStimulus(1'b0, 3'b011, 'h7FC, 64'd0, 0);
        checkOutput("ld_range_err", 64'(last_err), 64'd1);
        applyStimulus(1'b1, 3'b100, 'h100, 64'hDEAD, 0);
        checkOutput("store_f3_err", 64'(last_err), 64'd1);

        applyStimulus(1'b0, 3'b011, 'h010, 64'd0, 3);
        applyStimulus(1'b0, 3'b010, 'h002, 64'd0, 0);
        applyStimulus(1'b0, 3'b011, 'h7F8, 64'd0, 0);

        // Reset while the load is waiting on memory data.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 'h010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_mid_strobe", 64'(mem_rd_en), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_mid_rdata", resp_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic [2:0]  f3;
            int          addr;
            we   = 1'($urandom);
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(MEM_BYTES - 10, MEM_BYTES - 1))
                                               : int'($urandom_range(0, 63));
            applyStimulus(we, f3, addr, {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
